// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU command initiator.
// No logic; types and constants only.
// No flow control of its own.
package alu_pkg;

    localparam int RESULT_W = 16;
    localparam int OPND_W   = 8;

    // Any opcode with bit 2 set selects MUL; OP_MUL is its canonical encoding.
    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } master_state_e;

endpackage

// File: rtl/alu_cmd_master.sv
// Command initiator for a start/done ALU: launches one tagged op, waits for done or timeout.
// Latency: rsp_valid 3 cycles after accept for a 1-cycle ALU, 1 cycle for NOP.
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until rsp_ready.
module alu_cmd_master
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_opcode,
    input  logic [OPND_W-1:0]   cmd_a,
    input  logic [OPND_W-1:0]   cmd_b,
    input  logic [TAG_W-1:0]    cmd_tag,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RESULT_W-1:0] rsp_result,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic                rsp_err,
    output logic                alu_start,
    output logic [2:0]          alu_opcode,
    output logic [OPND_W-1:0]   alu_a,
    output logic [OPND_W-1:0]   alu_b,
    input  logic [RESULT_W-1:0] alu_result,
    input  logic                alu_done,
    output logic [7:0]          err_cnt,
    output logic                busy
);

    localparam int               TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    master_state_e    state;
    master_state_e    state_nxt;
    logic [TMR_W-1:0] timer;
    logic             timeout;
    logic             cmd_fire;
    logic             cmd_is_nop;

    assign timeout    = (timer == TMR_LAST);
    assign cmd_fire   = (state == IDLE) && cmd_valid;
    assign cmd_is_nop = (cmd_opcode == OP_NOP);

    // State register; reset drops any in-flight op without a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; done in LAUNCH is stale and deliberately not looked at.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = cmd_is_nop ? RESP : LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (alu_done || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs are pure state decodes, so cmd_ready has no path from any input.
    always_comb begin
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        alu_start = (state == LAUNCH);
        busy      = (state != IDLE);
    end

    // Datapath: operands latched on accept and left alone afterwards so the ALU bus stays quiet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_tag    <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            timer      <= '0;
            err_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        alu_opcode <= cmd_opcode;
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        rsp_tag    <= cmd_tag;
                        if (cmd_is_nop) begin
                            rsp_result <= '0;
                            rsp_err    <= 1'b0;
                        end
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (alu_done) begin
                        rsp_result <= alu_result;
                        rsp_err    <= 1'b0;
                    end else if (timeout) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_master.sv
// Bench for alu_cmd_master with a behavioural ALU of programmable latency.
// Expected responses are queued on accept and popped when the response handshakes.
// rsp_ready backpressure and stray alu_done pulses are driven from the stimulus block.
module tb_alu_cmd_master;
    import alu_pkg::*;

    localparam int TO    = 64;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_opcode;
    logic [7:0]        cmd_a;
    logic [7:0]        cmd_b;
    logic [TAG_W-1:0]  cmd_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_result;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;
    logic              alu_start;
    logic [2:0]        alu_opcode;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [15:0]       alu_result;
    logic              alu_done;
    logic [7:0]        err_cnt;
    logic              busy;

    always #5 clk = ~clk;

    alu_cmd_master #(.TIMEOUT_CYCLES(TO), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_done(alu_done),
        .err_cnt(err_cnt), .busy(busy)
    );

    typedef struct packed {
        logic [15:0]      res;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    rsp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_start = 0;
    int   n_rsp   = 0;
    int   hold_errs = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, obs, exp);
        end
    endtask

    // ---------------- behavioural ALU ----------------
    logic        alu_en  = 1'b1;
    int          alu_lat = 1;
    int          pend    = 0;
    logic        done_m  = 1'b0;
    logic        stray   = 1'b0;
    logic [15:0] res_m   = 16'h0;

    assign alu_done   = done_m | stray;
    assign alu_result = res_m;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] aw;
        logic [15:0] bw;
        aw = {8'h00, a};
        bw = {8'h00, b};
        if (op[2]) return aw * bw;
        case (op)
            3'b001:  return aw + bw;
            3'b010:  return aw & bw;
            3'b011:  return aw ^ bw;
            default: return 16'h0000;
        endcase
    endfunction

    // ALU answers alu_lat cycles after the start pulse; not reset, so a late done can outlive a DUT reset.
    always @(posedge clk) begin
        done_m <= 1'b0;
        if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                done_m <= 1'b1;
                res_m  <= alu_fn(alu_opcode, alu_a, alu_b);
            end
        end
        if (alu_start && alu_en) begin
            if (alu_lat <= 1) begin
                done_m <= 1'b1;
                res_m  <= alu_fn(alu_opcode, alu_a, alu_b);
            end else begin
                pend <= alu_lat - 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor and scoreboard pop.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_t e;
            n_rsp++;
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_result", 64'(rsp_result), 64'(e.res));
                check("rsp_tag",    64'(rsp_tag),    64'(e.tag));
                check("rsp_err",    64'(rsp_err),    64'(e.err));
            end
        end
    end

    // Start-pulse counter and operand-hold watcher for the WAIT phase.
    logic [18:0] held = '0;
    always @(negedge clk) begin
        if (alu_start) begin
            n_start++;
            held = {alu_opcode, alu_a, alu_b};
        end else if (rst_n && busy && !rsp_valid && ({alu_opcode, alu_a, alu_b} != held)) begin
            hold_errs++;
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [TAG_W-1:0] tag, input logic [15:0] er, input logic ee,
                        output int acc);
        rsp_t e;
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_tag    = tag;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            check("cmd_accept", 64'(cmd_ready), 64'd1);
        end else begin
            e.res = er;
            e.tag = tag;
            e.err = ee;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int acc, output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = cyc - acc;
                break;
            end
        end
        if (lat < 0) check("rsp_timeout", 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int lat;
        int s0;
        int h0;
        int r0;
        int bad;
        rsp_t e;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = 3'b000;
        cmd_a      = 8'h00;
        cmd_b      = 8'h00;
        cmd_tag    = '0;
        rsp_ready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state",
              {12'b0, cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_err, alu_start,
               alu_opcode, alu_a, alu_b, err_cnt, busy},
              {12'b0, 1'b1, 51'b0});
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: ADD, single-cycle ALU, one start pulse, response in cycle 3.
        s0 = n_start;
        send(3'b001, 8'h0F, 8'h01, 4'd3, 16'h0010, 1'b0, acc);
        wait_rsp(acc, lat);
        check("add_latency", 64'(lat), 64'd3);
        check("add_start_pulses", 64'(n_start - s0), 64'd1);

        // 2: MUL with a slower ALU; operands must not move during WAIT.
        alu_lat = 3;
        h0 = hold_errs;
        send(3'b100, 8'hFF, 8'hFF, 4'd9, 16'hFE01, 1'b0, acc);
        wait_rsp(acc, lat);
        check("mul_latency", 64'(lat), 64'd5);
        check("mul_hold", 64'(hold_errs - h0), 64'd0);
        alu_lat = 1;

        // 3: NOP never starts the ALU and answers next cycle; a stray done in IDLE first.
        @(posedge clk); #1; stray = 1'b1;
        @(posedge clk); #1; stray = 1'b0;
        s0 = n_start;
        send(3'b000, 8'h55, 8'hAA, 4'd2, 16'h0000, 1'b0, acc);
        wait_rsp(acc, lat);
        check("nop_latency", 64'(lat), 64'd1);
        check("nop_start_pulses", 64'(n_start - s0), 64'd0);

        // 4: XOR held under 5 cycles of backpressure, stray done during RESP.
        @(posedge clk); #1; rsp_ready = 1'b0;
        send(3'b011, 8'hF0, 8'h3C, 4'd4, 16'h00CC, 1'b0, acc);
        wait_rsp(acc, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (rsp_result !== 16'h00CC || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
            if (i == 2) begin
                @(posedge clk); #1; stray = 1'b1;
                @(negedge clk);
                if (rsp_result !== 16'h00CC || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
                @(posedge clk); #1; stray = 1'b0;
                @(negedge clk);
                if (rsp_result !== 16'h00CC || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
            end
        end
        check("xor_hold_under_bp", 64'(bad), 64'd0);
        // Release the response with the next command already valid in the same cycle.
        @(posedge clk); #1;
        rsp_ready  = 1'b1;
        cmd_valid  = 1'b1;
        cmd_opcode = 3'b001;
        cmd_a      = 8'h20;
        cmd_b      = 8'h22;
        cmd_tag    = 4'd5;
        @(negedge clk);
        check("bp_rdy_during_resp", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_after_resp", 64'(cmd_ready), 64'd1);
        acc   = cyc;
        e.res = 16'h0042;
        e.tag = 4'd5;
        e.err = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1; cmd_valid = 1'b0;
        wait_rsp(acc, lat);
        check("bp_next_latency", 64'(lat), 64'd3);

        // 5: ALU never answers -> timeout after LAUNCH plus TO WAIT cycles.
        alu_en = 1'b0;
        h0 = hold_errs;
        send(3'b010, 8'hAB, 8'hCD, 4'd8, 16'h0000, 1'b1, acc);
        wait_rsp(acc, lat);
        check("timeout_latency", 64'(lat), 64'(TO + 2));
        check("timeout_hold", 64'(hold_errs - h0), 64'd0);
        @(negedge clk);
        check("err_cnt_one", 64'(err_cnt), 64'd1);
        alu_en = 1'b1;
        send(3'b001, 8'h11, 8'h22, 4'd10, 16'h0033, 1'b0, acc);
        wait_rsp(acc, lat);
        check("post_timeout_latency", 64'(lat), 64'd3);

        // 6: reset during WAIT of a MUL, then a late done must be ignored.
        alu_lat = 6;
        send(3'b100, 8'h03, 8'h04, 4'd6, 16'h000C, 1'b0, acc);
        repeat (2) @(negedge clk);
        check("mul_in_wait", 64'({busy, alu_start, rsp_valid}), 64'b100);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        sb.delete();
        r0 = n_rsp;
        @(negedge clk);
        check("reset_mid_wait",
              {12'b0, cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_err, alu_start,
               alu_opcode, alu_a, alu_b, err_cnt, busy},
              {12'b0, 1'b1, 51'b0});
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("late_done_ignored", 64'(bad), 64'd0);
        check("no_rsp_after_reset", 64'(n_rsp - r0), 64'd0);
        alu_lat = 1;
        send(3'b001, 8'h7F, 8'h01, 4'd7, 16'h0080, 1'b0, acc);
        wait_rsp(acc, lat);
        check("post_reset_latency", 64'(lat), 64'd3);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
